// File: rtl/a2d_pkg.sv
// Shared types and constants for the A2D scan monitor slice.
package a2d_pkg;

    localparam int CH_IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } scan_state_t;

endpackage

// File: rtl/a2d_scan_seq.sv
// Period timer plus round-robin scan FSM driving the SPI A2D master handshake.
module a2d_scan_seq
    import a2d_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter int PERIOD_W = 19
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cnv_cmplt_i,
    output logic                strt_cnv_o,
    output logic [CH_IDX_W-1:0] chnnl_o,
    output logic                wr_en_o,
    output logic [CH_IDX_W-1:0] wr_idx_o,
    output logic                scan_done_o,
    output logic                tick_drop_o
);

    scan_state_t         state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q;
    logic [CH_IDX_W-1:0] ch_idx_q, ch_idx_d;
    logic                strt_cnv_q, strt_cnv_d;
    logic                scan_done_q, scan_done_d;
    logic                tick;
    logic                last_ch;

    assign tick    = &cnt_q;
    assign last_ch = (ch_idx_q == CH_IDX_W'(NUM_CH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ch_idx_q    <= '0;
            strt_cnv_q  <= 1'b0;
            scan_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_q + 1'b1;
            ch_idx_q    <= ch_idx_d;
            strt_cnv_q  <= strt_cnv_d;
            scan_done_q <= scan_done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ch_idx_d = ch_idx_q;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    ch_idx_d = '0;
                    state_d  = REQ;
                end
            end
            REQ: state_d = WAIT;
            WAIT: begin
                if (cnv_cmplt_i) begin
                    if (last_ch) begin
                        state_d = IDLE;
                    end else begin
                        ch_idx_d = ch_idx_q + 1'b1;
                        state_d  = REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // strt_cnv is registered from the next state so it is high exactly while in REQ
    always_comb begin
        wr_en_o     = (state_q == WAIT) && cnv_cmplt_i;
        scan_done_d = wr_en_o && last_ch;
        strt_cnv_d  = (state_d == REQ);
        tick_drop_o = tick && (state_q != IDLE);
    end

    assign strt_cnv_o  = strt_cnv_q;
    assign chnnl_o     = ch_idx_q;
    assign wr_idx_o    = ch_idx_q;
    assign scan_done_o = scan_done_q;

endmodule

// File: rtl/a2d_scan_monitor.sv
// A2D scan-and-display: result register file, display selector, LED mux, overrun flag.
// Optional peak-hold capture with clr_pk port when A2D_PEAK_HOLD_EN is defined.
module a2d_scan_monitor
    import a2d_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter int RES_W    = 12,
    parameter int LED_W    = 8,
    parameter int PERIOD_W = 19
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sel_pls,
    input  logic                auto_scrl,
`ifdef A2D_PEAK_HOLD_EN
    input  logic                clr_pk,
`endif
    output logic                strt_cnv,
    output logic [2:0]          chnnl,
    input  logic                cnv_cmplt,
    input  logic [RES_W-1:0]    res,
    output logic [LED_W-1:0]    led,
    output logic [2:0]          disp,
    output logic                scan_done,
    output logic                overrun
);

    logic                wr_en;
    logic [CH_IDX_W-1:0] wr_idx;
    logic                tick_drop;
    logic                clr;
    logic [NUM_CH-1:0]   wr_sel;
    logic [RES_W-1:0]    res_reg_q [NUM_CH];
    logic [CH_IDX_W-1:0] disp_q, disp_d;
    logic                overrun_q;
    logic [LED_W-1:0]    led_mux;

    a2d_scan_seq #(
        .NUM_CH   (NUM_CH),
        .PERIOD_W (PERIOD_W)
    ) u_seq (
        .clk         (clk),
        .rst_n       (rst_n),
        .cnv_cmplt_i (cnv_cmplt),
        .strt_cnv_o  (strt_cnv),
        .chnnl_o     (chnnl),
        .wr_en_o     (wr_en),
        .wr_idx_o    (wr_idx),
        .scan_done_o (scan_done),
        .tick_drop_o (tick_drop)
    );

`ifdef A2D_PEAK_HOLD_EN
    assign clr = clr_pk;
`else
    assign clr = 1'b0;
`endif

    always_comb begin
        wr_sel = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            wr_sel[c] = wr_en && (wr_idx == CH_IDX_W'(c));
`ifdef A2D_PEAK_HOLD_EN
            wr_sel[c] = wr_sel[c] && (res > res_reg_q[c]);
`endif
        end
    end

    // Clear wins over a capture landing in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < NUM_CH; c++) res_reg_q[c] <= '0;
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (clr) res_reg_q[c] <= '0;
                else if (wr_sel[c]) res_reg_q[c] <= res;
            end
        end
    end

    // Coincident sel_pls and auto-scroll events collapse into a single step
    always_comb begin
        disp_d = disp_q;
        if (sel_pls || (auto_scrl && scan_done)) begin
            if (disp_q == CH_IDX_W'(NUM_CH - 1)) disp_d = '0;
            else disp_d = disp_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            disp_q    <= disp_d;
            overrun_q <= overrun_q | tick_drop;
        end
    end

    always_comb begin
        led_mux = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (disp_q == CH_IDX_W'(c)) led_mux = res_reg_q[c][RES_W-1 -: LED_W];
        end
    end

    assign led     = led_mux;
    assign disp    = disp_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_a2d_scan_monitor.sv
// Self-checking bench for a2d_scan_monitor with an A2D responder and a behavioural model.
module tb_a2d_scan_monitor;

    localparam int NCH    = 3;
    localparam int RW     = 12;
    localparam int LW     = 8;
    localparam int PW     = 4;
    localparam int PERIOD = 1 << PW;

    typedef struct {
        int cyc;
        int ch;
        int lat;
    } req_t;

    logic          clk;
    logic          rst_n;
    logic          sel_pls;
    logic          auto_scrl;
    logic          clr_pk_tb;
    logic          strt_cnv;
    logic [2:0]    chnnl;
    logic          cnv_cmplt;
    logic [RW-1:0] res;
    logic [LW-1:0] led;
    logic [2:0]    disp;
    logic          scan_done;
    logic          overrun;

    int checks = 0;
    int errors = 0;
    int cyc;

    // A2D responder state
    logic          resp_cmplt;
    logic [RW-1:0] resp_res;
    logic [2:0]    cmplt_ch;
    logic          stray_cmplt;
    logic [RW-1:0] stray_res;
    int            a2d_lat;
    bit            fixed_mode;
    logic [RW-1:0] fix_val [0:7];
    req_t          log_q [$];

    // Reference model state
    logic [RW-1:0] exp_reg [0:7];
    int            exp_disp;
    bit            done_pend;

    assign cnv_cmplt = resp_cmplt | stray_cmplt;
    assign res       = stray_cmplt ? stray_res : resp_res;

    a2d_scan_monitor #(
        .NUM_CH   (NCH),
        .RES_W    (RW),
        .LED_W    (LW),
        .PERIOD_W (PW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel_pls   (sel_pls),
        .auto_scrl (auto_scrl),
`ifdef A2D_PEAK_HOLD_EN
        .clr_pk    (clr_pk_tb),
`endif
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .cnv_cmplt (cnv_cmplt),
        .res       (res),
        .led       (led),
        .disp      (disp),
        .scan_done (scan_done),
        .overrun   (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) cyc = 0;
            else cyc = cyc + 1;
        end
    end

    // A2D master model: completes a request lat cycles after strt_cnv
    initial begin
        int pend;
        int lat;
        logic [RW-1:0] val;
        logic [2:0] req_ch;
        pend = 0;
        resp_cmplt = 1'b0;
        resp_res = '0;
        cmplt_ch = '0;
        req_ch = '0;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                pend = 0;
                resp_cmplt = 1'b0;
            end else begin
                resp_cmplt = 1'b0;
                if (pend > 0) begin
                    pend = pend - 1;
                    if (pend == 0) begin
                        resp_cmplt = 1'b1;
                        resp_res = val;
                        cmplt_ch = req_ch;
                    end
                end
                if (strt_cnv) begin
                    lat = (a2d_lat == 0) ? int'($urandom_range(2, 5)) : a2d_lat;
                    log_q.push_back('{cyc, int'(chnnl), lat});
                    req_ch = chnnl;
                    val = fixed_mode ? fix_val[chnnl] : RW'($urandom_range(0, (1 << RW) - 1));
                    pend = lat - 1;
                end
            end
        end
    end

    // Behavioural model of the register file and display index
    initial begin
        bit adv;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < 8; i++) exp_reg[i] = '0;
                exp_disp = 0;
                done_pend = 1'b0;
            end else begin
                adv = sel_pls || (auto_scrl && done_pend);
                done_pend = 1'b0;
                if (adv) exp_disp = (exp_disp + 1) % NCH;
                if (clr_pk_tb) begin
                    for (int i = 0; i < 8; i++) exp_reg[i] = '0;
                end else if (resp_cmplt) begin
`ifdef A2D_PEAK_HOLD_EN
                    if (resp_res > exp_reg[cmplt_ch]) exp_reg[cmplt_ch] = resp_res;
`else
                    exp_reg[cmplt_ch] = resp_res;
`endif
                    if (int'(cmplt_ch) == NCH - 1) done_pend = 1'b1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [RW-1:0] r;
        check({tag, "_disp"}, 32'(disp), 32'(exp_disp));
        r = exp_reg[exp_disp];
        check({tag, "_led"}, 32'(led), 32'(r[RW-1 -: LW]));
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!scan_done && n < 100);
        check({tag, "_scan_done"}, 32'(scan_done), 32'd1);
    endtask

    task automatic pulse_sel();
        sel_pls = 1'b1;
        @(negedge clk);
        sel_pls = 1'b0;
    endtask

    // Request timing from the rules: scans start on period ticks taken while idle,
    // channels go in order, each next request follows its predecessor's completion.
    task automatic check_log(input string tag);
        int exp_e;
        int exp_c;
        int prev_end;
        prev_end = 0;
        for (int i = 0; i < log_q.size(); i++) begin
            if (i == 0 || log_q[i-1].ch == NCH - 1) begin
                exp_c = 0;
                exp_e = (i == 0) ? PERIOD : ((prev_end / PERIOD) + 1) * PERIOD;
            end else begin
                exp_c = log_q[i-1].ch + 1;
                exp_e = log_q[i-1].cyc + log_q[i-1].lat;
            end
            check($sformatf("%s_req%0d_cyc", tag, i), 32'(log_q[i].cyc), 32'(exp_e));
            check($sformatf("%s_req%0d_ch", tag, i), 32'(log_q[i].ch), 32'(exp_c));
            if (log_q[i].ch == NCH - 1) prev_end = log_q[i].cyc + log_q[i].lat;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_strt_cnv"}, 32'(strt_cnv), 32'd0);
        check({tag, "_chnnl"}, 32'(chnnl), 32'd0);
        check({tag, "_led"}, 32'(led), 32'd0);
        check({tag, "_disp"}, 32'(disp), 32'd0);
        check({tag, "_scan_done"}, 32'(scan_done), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        int d0;
        int n;
        rst_n = 1'b1;
        sel_pls = 1'b0;
        auto_scrl = 1'b0;
        clr_pk_tb = 1'b0;
        stray_cmplt = 1'b0;
        stray_res = '0;
        a2d_lat = 5;
        fixed_mode = 1'b1;
        for (int i = 0; i < 8; i++) fix_val[i] = '0;
        fix_val[0] = 12'hA50;
        fix_val[1] = 12'h3C0;
        fix_val[2] = 12'hFFF;
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // First scan: requests at 16/21/26, led shows channel 0
        wait_done("scan1");
        check("scan1_led", 32'(led), 32'hA5);
        check("scan1_disp", 32'(disp), 32'd0);
        check("scan1_overrun", 32'(overrun), 32'd0);
        check("scan1_reqs", 32'(log_q.size()), 32'd3);
        @(negedge clk);
        check("scan1_done_width", 32'(scan_done), 32'd0);

        pulse_sel();
        pulse_sel();
        check("sel2_disp", 32'(disp), 32'd2);
        check("sel2_led", 32'(led), 32'hFF);
        pulse_sel();
        check("sel3_disp_wrap", 32'(disp), 32'd0);
        check("sel3_led", 32'(led), 32'hA5);

        // Auto-scroll and button press in the same cycle
        auto_scrl = 1'b1;
        wait_done("auto");
        d0 = int'(disp);
        sel_pls = 1'b1;
        @(negedge clk);
        sel_pls = 1'b0;
        check("coincident_disp", 32'(disp), 32'((d0 + 1) % NCH));
        auto_scrl = 1'b0;
        check_model("coincident");

        // Stray completion while idle must not land anywhere
        wait_done("stray");
        stray_cmplt = 1'b1;
        stray_res = 12'h123;
        @(negedge clk);
        stray_cmplt = 1'b0;
        check_model("stray_a");
        pulse_sel();
        check_model("stray_b");
        pulse_sel();
        check_model("stray_c");

        // Randomised values, latencies, button presses and auto-scroll
        fixed_mode = 1'b0;
        a2d_lat = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (i % 8 == 0) check_model($sformatf("rand%0d", i));
            sel_pls = ($urandom_range(0, 6) == 0);
            if (i % 37 == 0) auto_scrl = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        sel_pls = 1'b0;
        auto_scrl = 1'b0;
        check("rand_overrun", 32'(overrun), 32'd0);

        // Slow A2D: scans overrun the period
        a2d_lat = 10;
        wait_done("slow1");
        wait_done("slow2");
        check("slow_overrun", 32'(overrun), 32'd1);
        check_model("slow");
        check_log("run1");

        // Reset while waiting for a conversion
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!strt_cnv && n < 40);
        check("midscan_strt_seen", 32'(strt_cnv), 32'd1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midscan_reset");
        log_q.delete();
        a2d_lat = 5;
        fixed_mode = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

`ifdef A2D_PEAK_HOLD_EN
        fix_val[0] = 12'h800;
        wait_done("pk1");
        check("pk1_led", 32'(led), 32'h80);
        fix_val[0] = 12'h400;
        wait_done("pk2");
        check("pk2_led", 32'(led), 32'h80);
        clr_pk_tb = 1'b1;
        fix_val[0] = 12'h100;
        @(negedge clk);
        clr_pk_tb = 1'b0;
        check("pk_clr_led", 32'(led), 32'h00);
        wait_done("pk3");
        check("pk3_led", 32'(led), 32'h10);
        check_model("pk3");
`else
        wait_done("post_reset");
        check("post_reset_led", 32'(led), 32'hA5);
        check_model("post_reset");
`endif
        check("post_reset_overrun", 32'(overrun), 32'd0);
        check_log("run2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
